// File: rtl/vec_mem_requester.sv
// vec_mem_requester
// -----------------
// Pipeline-side initiator for the 16-lane banked vector memory controller.
// Takes one scalar or vector load/store at a time from the execute stage,
// drives the controller port for one issue cycle, waits out the bank read
// latency for loads, and returns load data or store completion to the
// consumer. It is the controller's only master.
//
// Parameters:
//   RD_LAT  cycles from address presented until mem_q is valid (1..4)
//   AW      word address width, equal to the controller address width
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   req_valid / req_ready          request handshake
//   req_store, req_vec             store/load select, vector/scalar select
//   req_addr, req_wdata            base word address, 16x16 store data
//   resp_valid / resp_ready        response handshake
//   resp_store, resp_err           store completion flag, rejection flag
//   resp_data                      16x16 load data (0 for stores)
//   mem_address, mem_data          controller address and write data
//   mem_wren, mem_vec_scalar       controller write enable, vector select
//   mem_q                          controller read data
//
// Optional feature: define VEC_MEM_ADDR_CHECK_EN to reject vector requests
// whose 16-lane span would run past the top of the address space. Without
// it, resp_err is always 0 and lane addresses wrap inside the controller.
module vec_mem_requester #(
  parameter int RD_LAT = 1,
  parameter int AW     = 18
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_store,
  input  logic                req_vec,
  input  logic [AW-1:0]       req_addr,
  input  logic [15:0][15:0]   req_wdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic                resp_store,
  output logic                resp_err,
  output logic [15:0][15:0]   resp_data,
  output logic [AW-1:0]       mem_address,
  output logic [15:0][15:0]   mem_data,
  output logic                mem_wren,
  output logic                mem_vec_scalar,
  input  logic [15:0][15:0]   mem_q
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [15:0][15:0]   wdata_q, wdata_d;
  logic                store_q, store_d;
  logic                vec_q, vec_d;
  logic                rstore_q, rstore_d;
  logic                err_q, err_d;
  logic [15:0][15:0]   rdata_q, rdata_d;
  logic                reject;

`ifdef VEC_MEM_ADDR_CHECK_EN
  // Highest base address whose 16 lanes still fit: 2^AW - 16.
  localparam logic [AW-1:0] ADDR_LIM = {AW{1'b1}} - AW'(15);
  assign reject = req_vec && (req_addr > ADDR_LIM);
`else
  // Nothing is ever rejected, so err_q never leaves its reset value of 0.
  assign reject = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      store_q  <= 1'b0;
      vec_q    <= 1'b0;
      rstore_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      store_q  <= store_d;
      vec_q    <= vec_d;
      rstore_q <= rstore_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    store_d  = store_q;
    vec_d    = vec_q;
    rstore_d = rstore_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          rstore_d = req_store;
          rdata_d  = '0;
          err_d    = 1'b0;
          if (reject) begin
            // Rejected requests skip the controller entirely.
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            addr_d  = req_addr;
            wdata_d = req_wdata;
            store_d = req_store;
            vec_d   = req_vec;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (store_q) begin
          state_d = RESP;
        end else begin
          cnt_d   = 3'(RD_LAT);
          state_d = WAIT;
        end
      end
      WAIT: begin
        // mem_q is valid in the cycle the counter shows 1.
        if (cnt_q <= 3'd1) begin
          rdata_d    = '0;
          rdata_d[0] = mem_q[0];
          if (vec_q) rdata_d = mem_q;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Decoded from state so an asynchronous reset drops them at once.
  assign req_ready      = (state_q == IDLE) && !rst;
  assign resp_valid     = (state_q == RESP);
  assign mem_wren       = (state_q == ISSUE) && store_q;
  assign mem_address    = addr_q;
  assign mem_data       = wdata_q;
  assign mem_vec_scalar = vec_q;
  assign resp_store     = rstore_q;
  assign resp_err       = err_q;
  assign resp_data      = rdata_q;

endmodule

// File: tb/tb_vec_mem_requester.sv
module tb_vec_mem_requester;

  localparam int AW     = 18;
  localparam int RD_LAT = 1;

  typedef logic [15:0][15:0] lanes_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          req_valid, req_ready, req_store, req_vec;
  logic [AW-1:0] req_addr;
  lanes_t        req_wdata;
  logic          resp_valid, resp_ready, resp_store, resp_err;
  lanes_t        resp_data;
  logic [AW-1:0] mem_address;
  lanes_t        mem_data;
  logic          mem_wren, mem_vec_scalar;
  lanes_t        mem_q;

  // Second instance with a 3-cycle read latency.
  logic          req_valid3, req_ready3, req_store3, req_vec3;
  logic [AW-1:0] req_addr3;
  lanes_t        req_wdata3;
  logic          resp_valid3, resp_ready3, resp_store3, resp_err3;
  lanes_t        resp_data3;
  logic [AW-1:0] mem_address3;
  lanes_t        mem_data3;
  logic          mem_wren3, mem_vec_scalar3;
  lanes_t        mem_q3;

  vec_mem_requester #(.RD_LAT(RD_LAT), .AW(AW)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_vec(req_vec), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_store(resp_store),
    .resp_err(resp_err), .resp_data(resp_data),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
    .mem_vec_scalar(mem_vec_scalar), .mem_q(mem_q)
  );

  vec_mem_requester #(.RD_LAT(3), .AW(AW)) u_dut3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_store(req_store3),
    .req_vec(req_vec3), .req_addr(req_addr3), .req_wdata(req_wdata3),
    .resp_valid(resp_valid3), .resp_ready(resp_ready3), .resp_store(resp_store3),
    .resp_err(resp_err3), .resp_data(resp_data3),
    .mem_address(mem_address3), .mem_data(mem_data3), .mem_wren(mem_wren3),
    .mem_vec_scalar(mem_vec_scalar3), .mem_q(mem_q3)
  );

  // Controller model, RD_LAT = 1: lane i lives at word (address + i) mod 2^AW.
  logic [15:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_wren) begin
      if (mem_vec_scalar) begin
        for (int i = 0; i < 16; i++) mem[mem_address + AW'(i)] <= mem_data[i];
      end else begin
        mem[mem_address] <= mem_data[0];
      end
    end
    for (int i = 0; i < 16; i++) mem_q[i] <= mem[mem_address + AW'(i)];
  end

  // Controller model, RD_LAT = 3: data is a pattern of the address seen 3 cycles ago.
  function automatic lanes_t pat(input logic [AW-1:0] a);
    lanes_t r;
    for (int i = 0; i < 16; i++) r[i] = a[15:0] + 16'(i * 257);
    return r;
  endfunction

  logic [AW-1:0] a3_pipe [3];
  always @(posedge clk) begin
    a3_pipe[0] <= mem_address3;
    a3_pipe[1] <= a3_pipe[0];
    a3_pipe[2] <= a3_pipe[1];
  end
  always_comb mem_q3 = pat(a3_pipe[2]);

  int wren_cnt = 0;
  always @(negedge clk) if (mem_wren) wren_cnt <= wren_cnt + 1;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %h required %h", nm, act, exp);
  endtask

  typedef struct {
    logic          store;
    logic          vec;
    logic [AW-1:0] addr;
    logic [15:0]   wbase;
    logic [15:0]   winc;
    int            lat;    // resp_valid first seen in cycle T+lat
    logic          err;
    logic [15:0]   e0;     // expected lane 0
    logic [15:0]   erest;  // expected lane i = erest + i*einc, i >= 1
    logic [15:0]   einc;
    logic [15:0]   mask;   // lanes that are compared
  } vec_t;

  typedef struct {
    logic   store;
    logic   err;
    lanes_t data;
    logic [15:0] mask;
    int     lat;
    int     wren;
  } exp_t;

  exp_t sbq[$];
  vec_t rows[11];

  function automatic vec_t mk(input logic st, input logic ve, input logic [AW-1:0] ad,
                              input logic [15:0] wb, input logic [15:0] wi, input int lt,
                              input logic er, input logic [15:0] x0, input logic [15:0] xr,
                              input logic [15:0] xi, input logic [15:0] mk_);
    vec_t v;
    v.store = st; v.vec = ve; v.addr = ad; v.wbase = wb; v.winc = wi; v.lat = lt;
    v.err = er; v.e0 = x0; v.erest = xr; v.einc = xi; v.mask = mk_;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    exp_t          e;
    lanes_t        m;
    int            k;
    int            wren0;
    logic [AW-1:0] a1;
    logic          stable;
    k = 0;
    while (!req_ready && k < 50) begin tick(); k++; end
    check({nm, ".ready"}, req_ready, 1'b1);
    req_store = v.store;
    req_vec   = v.vec;
    req_addr  = v.addr;
    for (int i = 0; i < 16; i++) req_wdata[i] = v.wbase + 16'(i) * v.winc;
    req_valid = 1'b1;
    e.store = v.store;
    e.err   = v.err;
    e.lat   = v.lat;
    e.mask  = v.mask;
    e.wren  = (v.store && !v.err) ? 1 : 0;
    for (int i = 0; i < 16; i++) e.data[i] = (i == 0) ? v.e0 : v.erest + 16'(i) * v.einc;
    sbq.push_back(e);
    wren0 = wren_cnt;
    tick();
    req_valid = 1'b0;
    a1 = mem_address;
    stable = 1'b1;
    k = 1;
    while (!resp_valid && k < 20) begin
      tick();
      k++;
      if (mem_address !== a1) stable = 1'b0;
    end
    e = sbq.pop_front();
    for (int i = 0; i < 16; i++) m[i] = e.mask[i] ? 16'hFFFF : 16'h0000;
    check({nm, ".latency"}, 32'(k), 32'(e.lat));
    check({nm, ".resp_store"}, resp_store, e.store);
    check({nm, ".resp_err"}, resp_err, e.err);
    check({nm, ".resp_data"}, resp_data & m, e.data & m);
    check({nm, ".wren_pulses"}, 32'(wren_cnt - wren0), 32'(e.wren));
    check({nm, ".addr_stable"}, stable, 1'b1);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check({nm, ".resp_done"}, resp_valid, 1'b0);
  endtask

  task automatic run3(input logic ve, input logic [AW-1:0] ad, input string nm);
    lanes_t exp_d;
    int     k;
    logic   stable;
    req_vec3 = ve; req_addr3 = ad; req_store3 = 1'b0; req_valid3 = 1'b1;
    tick();
    req_valid3 = 1'b0;
    check({nm, ".address"}, mem_address3, ad);
    stable = 1'b1;
    k = 1;
    while (!resp_valid3 && k < 20) begin
      if (mem_address3 !== ad) stable = 1'b0;
      tick();
      k++;
    end
    exp_d = pat(ad);
    if (!ve) exp_d[15:1] = '0;
    check({nm, ".latency"}, 32'(k), 32'd5);
    check({nm, ".addr_stable"}, stable, 1'b1);
    check({nm, ".resp_data"}, resp_data3, exp_d);
    resp_ready3 = 1'b1;
    tick();
    resp_ready3 = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    lanes_t d0;
    logic   late;
    int     w0;

    rst = 1'b1;
    req_valid = 0; req_store = 0; req_vec = 0; req_addr = '0; req_wdata = '0; resp_ready = 0;
    req_valid3 = 0; req_store3 = 0; req_vec3 = 0; req_addr3 = '0; req_wdata3 = '0; resp_ready3 = 0;

    //            st vec addr      wbase     winc  lat err e0        erest     einc  mask
    rows[0] = mk(1, 1, 18'h00100, 16'h1000, 16'd1, 2, 0, 16'h0000, 16'h0000, 16'd0, 16'hFFFF);
    rows[1] = mk(0, 1, 18'h00100, 16'h0000, 16'd0, 3, 0, 16'h1000, 16'h1000, 16'd1, 16'hFFFF);
    rows[2] = mk(1, 1, 18'h00200, 16'h5555, 16'd0, 2, 0, 16'h0000, 16'h0000, 16'd0, 16'hFFFF);
    rows[3] = mk(1, 0, 18'h00200, 16'hBEEF, 16'd0, 2, 0, 16'h0000, 16'h0000, 16'd0, 16'hFFFF);
    rows[4] = mk(0, 1, 18'h00200, 16'h0000, 16'd0, 3, 0, 16'hBEEF, 16'h5555, 16'd0, 16'hFFFF);
    rows[5] = mk(0, 0, 18'h00200, 16'h0000, 16'd0, 3, 0, 16'hBEEF, 16'h0000, 16'd0, 16'hFFFF);
    rows[6] = mk(1, 1, 18'h3FFF0, 16'h2000, 16'd1, 2, 0, 16'h0000, 16'h0000, 16'd0, 16'hFFFF);
    rows[7] = mk(0, 1, 18'h3FFF0, 16'h0000, 16'd0, 3, 0, 16'h2000, 16'h2000, 16'd1, 16'hFFFF);
`ifdef VEC_MEM_ADDR_CHECK_EN
    rows[8] = mk(0, 1, 18'h3FFF1, 16'h0000, 16'd0, 1, 1, 16'h0000, 16'h0000, 16'd0, 16'hFFFF);
`else
    // Lane 15 wraps to word 0, which holds nothing known here.
    rows[8] = mk(0, 1, 18'h3FFF1, 16'h0000, 16'd0, 3, 0, 16'h2001, 16'h2001, 16'd1, 16'h7FFF);
`endif
    rows[9] = mk(0, 0, 18'h3FFFF, 16'h0000, 16'd0, 3, 0, 16'h200F, 16'h0000, 16'd0, 16'hFFFF);
`ifdef VEC_MEM_ADDR_CHECK_EN
    rows[10] = mk(1, 1, 18'h3FFF8, 16'h7000, 16'd1, 1, 1, 16'h0000, 16'h0000, 16'd0, 16'hFFFF);
`else
    rows[10] = mk(1, 1, 18'h3FFF8, 16'h7000, 16'd1, 2, 0, 16'h0000, 16'h0000, 16'd0, 16'hFFFF);
`endif

    // Reset state
    tick(); tick();
    check("rst.req_ready", req_ready, 1'b0);
    check("rst.resp_valid", resp_valid, 1'b0);
    check("rst.mem_wren", mem_wren, 1'b0);
    check("rst.resp_err", resp_err, 1'b0);
    check("rst.mem_address", mem_address, '0);
    check("rst.mem_data", mem_data, '0);
    check("rst.resp_data", resp_data, '0);
    check("rst.mem_vec_scalar", mem_vec_scalar, 1'b0);
    rst = 1'b0;
    tick();
    check("post_rst.req_ready", req_ready, 1'b1);

    for (int r = 0; r < 11; r++) run_vec(rows[r], $sformatf("row%0d", r));

    // Response backpressure, with a competing request held on the input.
    req_vec = 1'b1; req_store = 1'b0; req_addr = 18'h00100; req_valid = 1'b1;
    tick();
    req_store = 1'b1; req_addr = 18'h00040; req_wdata = '1;
    w0 = wren_cnt;
    for (int k = 0; k < 20 && !resp_valid; k++) tick();
    d0 = resp_data;
    for (int i = 0; i < 16; i++) check("bp.data_value", d0[i], 16'h1000 + 16'(i));
    for (int c = 0; c < 5; c++) begin
      check("bp.resp_valid", resp_valid, 1'b1);
      check("bp.resp_data_stable", resp_data, d0);
      check("bp.req_ready", req_ready, 1'b0);
      tick();
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("bp.req_ready_after", req_ready, 1'b1);
    check("bp.resp_valid_after", resp_valid, 1'b0);
    check("bp.held_req_ignored", 32'(wren_cnt - w0), 32'd0);
    req_valid = 1'b0; req_store = 1'b0;

    // Reset during WAIT of a load.
    req_vec = 1'b1; req_addr = 18'h00200; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    check("rw.in_wait", resp_valid, 1'b0);
    rst = 1'b1;
    #1;
    check("rw.mem_wren", mem_wren, 1'b0);
    check("rw.resp_valid", resp_valid, 1'b0);
    check("rw.resp_err", resp_err, 1'b0);
    check("rw.req_ready", req_ready, 1'b0);
    tick();
    rst = 1'b0;
    late = 1'b0;
    for (int c = 0; c < 6; c++) begin tick(); if (resp_valid) late = 1'b1; end
    check("rw.no_stale_resp", late, 1'b0);
    run_vec(rows[4], "rw.after");

    // Reset during ISSUE of a store: the write enable must drop at once.
    req_vec = 1'b1; req_store = 1'b1; req_addr = 18'h00300; req_wdata = '1; req_valid = 1'b1;
    tick();
    req_valid = 1'b0; req_store = 1'b0;
    check("ri.mem_wren_issue", mem_wren, 1'b1);
    rst = 1'b1;
    #1;
    check("ri.mem_wren_rst", mem_wren, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    check("ri.resp_valid", resp_valid, 1'b0);
    check("ri.req_ready", req_ready, 1'b1);

    // RD_LAT = 3 instance.
    run3(1'b1, 18'h00123, "lat3.vec");
    run3(1'b0, 18'h00456, "lat3.scalar");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vec_mem_requester.md
# vec_mem_requester

Pipeline-side initiator for the 16-lane banked vector memory controller. Accepts one scalar or vector load/store at a time from the execute stage over a valid/ready handshake, drives the controller's address/data/write-enable/vector-select port, waits out the bank read latency, and returns the load data or store completion over a second valid/ready handshake. Sits between the vector execute stage and the memory controller, and is that controller's only master.

## Interface
Parameters:
- RD_LAT, 1: cycles from address presented to controller until `mem_q` is valid (1..4)
- AW, 18: address width; must equal the controller address width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_store  in  1  1 = store, 0 = load
- req_vec  in  1  1 = 16-lane vector access, 0 = scalar (lane 0 only)
- req_addr  in  AW  base word address
- req_wdata  in  16x16  store data, lane i = element i
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes response
- resp_store  out  1  response is a store completion
- resp_err  out  1  request rejected (see Configuration)
- resp_data  out  16x16  load data
- mem_address  out  AW  to controller address
- mem_data  out  16x16  to controller data
- mem_wren  out  1  to controller write enable
- mem_vec_scalar  out  1  to controller vector select
- mem_q  in  16x16  from controller read data

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: `req_ready` = 1. On `req_valid && req_ready`, the block registers addr/wdata/store/vec into the `mem_*` outputs and enters ISSUE.
- ISSUE (1 cycle): `mem_wren` = `req_store` captured. Store: go to RESP. Load: go to WAIT with latency counter = RD_LAT.
- WAIT: `mem_wren` = 0. `mem_address` and `mem_vec_scalar` are held stable. The counter decrements each cycle. In the cycle the counter reaches 1, `mem_q` is captured into `resp_data` and the FSM goes to RESP.
- Scalar load: `resp_data` lane 0 = `mem_q` lane 0, lanes 1..15 = 0. Vector load: all 16 lanes are copied.
- Scalar store: `mem_vec_scalar` = 0, so only lane 0 is written. `mem_data` still carries all lanes.
- RESP: `resp_valid` = 1. `resp_data`, `resp_store` and `resp_err` are held until `resp_ready`. On handshake the FSM goes to IDLE. There is no bypass, so the next request is accepted no earlier than the cycle after the response handshake.
- `mem_wren` is 1 only in ISSUE for a store. It is never asserted in any other state.
- Store `resp_data` = 0.

## Timing
- Request accepted at edge T (a cycle where `req_valid && req_ready` is true at the rising edge).
- ISSUE occupies cycle T+1, with `mem_*` outputs valid.
- Store completion: `resp_valid` is asserted from cycle T+2.
- Load completion: `resp_valid` is asserted from cycle T+2+RD_LAT. With RD_LAT = 1, that is cycle T+3.
- Reset values: `mem_address` = 0, `mem_data` = 0, `mem_wren` = 0, `mem_vec_scalar` = 0, `resp_valid` = 0, `resp_store` = 0, `resp_err` = 0, `resp_data` = 0, state = IDLE.
- `req_ready` = 0 while `rst` is high.
- Reset mid-operation: the FSM returns to IDLE asynchronously, `mem_wren` drops immediately, and the pending response is discarded.
- `resp_valid` low with `resp_ready` high: no effect.
- Requests presented while not in IDLE are ignored; the requester must hold them.

## Configuration
- VEC_MEM_ADDR_CHECK_EN defined:
  - A vector request with `req_addr` > 2^AW − 16 is rejected at acceptance. It never enters ISSUE and `mem_wren` stays 0.
  - The FSM goes directly to RESP at T+1 with `resp_err` = 1, `resp_data` = 0, and `resp_store` = the request's `req_store`.
  - Scalar requests are never rejected.
- Undefined:
  - `resp_err` is tied 0.
  - All requests are issued, and lane addresses wrap modulo 2^AW inside the controller.

## Test plan
- Vector store then load:
  - Store addr 0x00100 with lanes = 0x1000+i. Completion must arrive at T+2 with `mem_wren` high for exactly 1 cycle.
  - Load from 0x00100. `resp_data` lane i must equal 0x1000+i, arriving at T+3 (RD_LAT = 1).
- Scalar store, then vector load:
  - Scalar store 0xBEEF at 0x00200, over background 0x5555.
  - Vector load from 0x00200 must return lane 0 = 0xBEEF and lanes 1..15 = 0x5555.
  - Scalar load from 0x00200 must return lane 0 = 0xBEEF and all other lanes 0.
- Response backpressure: hold `resp_ready` = 0 for 5 cycles.
  - `resp_valid` and `resp_data` must stay stable and `req_ready` must stay 0.
  - Handshake occurs in the 6th cycle; `req_ready` = 1 in the next cycle.
- RD_LAT = 3 build: a load response must arrive at T+5, with `mem_address` stable for cycles T+1..T+4.
- Reset during WAIT:
  - `mem_wren`, `resp_valid` and `resp_err` must be 0 while `rst` is high.
  - No response may appear after release.
  - The next request must complete normally.
- Address limit, with the macro on:
  - Vector load at 0x3FFF1 must give `resp_err` = 1 at T+1 with no `mem_wren` pulse.
  - Vector load at 0x3FFF0 must give `resp_err` = 0.
  - With the macro off, 0x3FFF1 must issue normally with `resp_err` = 0.
